// File: rtl/game_frame_scheduler.sv
// Frame request/acknowledge sequencer with coordinate double-buffering and jump-button debounce.
// Optional frame/overrun statistics counters are enabled by defining FRAME_STATS_EN.
module game_frame_scheduler #(
  parameter int unsigned COORD_W         = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               screen_ready,
  input  logic               button_press,
  input  logic               cpu_done,
  input  logic [COORD_W-1:0] cpu_dino_x,
  input  logic [COORD_W-1:0] cpu_dino_y,
  input  logic [COORD_W-1:0] cpu_obs_x,
  input  logic [COORD_W-1:0] cpu_obs_y,
  output logic               frame_req,
  output logic               btn_status,
  output logic [COORD_W-1:0] disp_dino_x,
  output logic [COORD_W-1:0] disp_dino_y,
  output logic [COORD_W-1:0] disp_obs_x,
  output logic [COORD_W-1:0] disp_obs_y,
  output logic [CNT_W-1:0]   frame_count,
  output logic [CNT_W-1:0]   overrun_count
);

  localparam int unsigned     DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LATCH} state_e;

  state_e             state_q, state_d;
  logic               sr_prev_q, sr_prev_d, frame_rise_q, frame_rise_d;
  logic               done_s1_q, done_s1_d, done_s2_q, done_s2_d;
  logic               done_prev_q, done_prev_d, done_rise_q, done_rise_d;
  logic               btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_last_q, btn_last_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               deb_level_q, deb_level_d;
  logic               sticky_q, sticky_d, btn_status_q, btn_status_d;
  logic               frame_req_q, frame_req_d;
  logic [COORD_W-1:0] dino_x_q, dino_x_d, dino_y_q, dino_y_d;
  logic [COORD_W-1:0] obs_x_q, obs_x_d, obs_y_q, obs_y_d;
  logic               latch_en_c;

  // Edge detection, synchronizers and button debounce
  always_comb begin
    sr_prev_d    = screen_ready;
    frame_rise_d = screen_ready & ~sr_prev_q;
    done_s1_d    = cpu_done;
    done_s2_d    = done_s1_q;
    done_prev_d  = done_s2_q;
    done_rise_d  = done_s2_q & ~done_prev_q;
    btn_s1_d     = button_press;
    btn_s2_d     = btn_s1_q;
    btn_last_d   = btn_s2_q;
    deb_cnt_d    = deb_cnt_q;
    deb_level_d  = deb_level_q;
    if (btn_s2_q != btn_last_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      deb_level_d = btn_last_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
    // A new debounced press outranks the clear issued by LATCH
    sticky_d = sticky_q;
    if (state_q == S_LATCH) sticky_d = 1'b0;
    if (deb_level_d && !deb_level_q) sticky_d = 1'b1;
    btn_status_d = deb_level_d | sticky_d;
  end

  // Frame FSM next-state and display buffer
  always_comb begin
    state_d    = state_q;
    latch_en_c = 1'b0;
    case (state_q)
      S_IDLE:  if (frame_rise_q) state_d = S_REQ;
      S_REQ:   if (done_rise_q) state_d = S_LATCH;
      S_LATCH: begin
        latch_en_c = 1'b1;
        state_d    = frame_rise_q ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    frame_req_d = (state_d == S_REQ);
    dino_x_d    = latch_en_c ? cpu_dino_x : dino_x_q;
    dino_y_d    = latch_en_c ? cpu_dino_y : dino_y_q;
    obs_x_d     = latch_en_c ? cpu_obs_x  : obs_x_q;
    obs_y_d     = latch_en_c ? cpu_obs_y  : obs_y_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sr_prev_q    <= 1'b0;
      frame_rise_q <= 1'b0;
      done_s1_q    <= 1'b0;
      done_s2_q    <= 1'b0;
      done_prev_q  <= 1'b0;
      done_rise_q  <= 1'b0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_last_q   <= 1'b0;
      deb_cnt_q    <= '0;
      deb_level_q  <= 1'b0;
      sticky_q     <= 1'b0;
      btn_status_q <= 1'b0;
      frame_req_q  <= 1'b0;
      dino_x_q     <= '0;
      dino_y_q     <= '0;
      obs_x_q      <= '0;
      obs_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      sr_prev_q    <= sr_prev_d;
      frame_rise_q <= frame_rise_d;
      done_s1_q    <= done_s1_d;
      done_s2_q    <= done_s2_d;
      done_prev_q  <= done_prev_d;
      done_rise_q  <= done_rise_d;
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      btn_last_q   <= btn_last_d;
      deb_cnt_q    <= deb_cnt_d;
      deb_level_q  <= deb_level_d;
      sticky_q     <= sticky_d;
      btn_status_q <= btn_status_d;
      frame_req_q  <= frame_req_d;
      dino_x_q     <= dino_x_d;
      dino_y_q     <= dino_y_d;
      obs_x_q      <= obs_x_d;
      obs_y_q      <= obs_y_d;
    end
  end

  assign frame_req   = frame_req_q;
  assign btn_status  = btn_status_q;
  assign disp_dino_x = dino_x_q;
  assign disp_dino_y = dino_y_q;
  assign disp_obs_x  = obs_x_q;
  assign disp_obs_y  = obs_y_q;

`ifdef FRAME_STATS_EN
  logic [CNT_W-1:0] frame_count_q, frame_count_d, overrun_count_q, overrun_count_d;

  // Frame count wraps; overrun count saturates at all-ones
  always_comb begin
    frame_count_d   = frame_count_q + CNT_W'(latch_en_c);
    overrun_count_d = overrun_count_q;
    if ((state_q == S_REQ) && frame_rise_q && (overrun_count_q != '1))
      overrun_count_d = overrun_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q   <= '0;
      overrun_count_q <= '0;
    end else begin
      frame_count_q   <= frame_count_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  assign frame_count   = frame_count_q;
  assign overrun_count = overrun_count_q;
`else
  assign frame_count   = '0;
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_game_frame_scheduler.sv
// Scoreboard bench for game_frame_scheduler; builds with or without FRAME_STATS_EN.
module tb_game_frame_scheduler;

  localparam int unsigned COORD_W = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEB     = 16;
`ifdef FRAME_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W-1:0] ox;
    logic [COORD_W-1:0] oy;
  } coord_t;

  logic               clk = 1'b0;
  logic               reset_n, screen_ready, button_press, cpu_done;
  logic [COORD_W-1:0] cpu_dino_x, cpu_dino_y, cpu_obs_x, cpu_obs_y;
  logic               frame_req, btn_status;
  logic [COORD_W-1:0] disp_dino_x, disp_dino_y, disp_obs_x, disp_obs_y;
  logic [CNT_W-1:0]   frame_count, overrun_count;

  coord_t sb_q[$];
  coord_t exp_disp;
  int     exp_frames, exp_ovr;
  int     n_checks, n_pass;

  game_frame_scheduler #(
    .COORD_W(COORD_W), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .screen_ready(screen_ready),
    .button_press(button_press), .cpu_done(cpu_done),
    .cpu_dino_x(cpu_dino_x), .cpu_dino_y(cpu_dino_y),
    .cpu_obs_x(cpu_obs_x), .cpu_obs_y(cpu_obs_y),
    .frame_req(frame_req), .btn_status(btn_status),
    .disp_dino_x(disp_dino_x), .disp_dino_y(disp_dino_y),
    .disp_obs_x(disp_obs_x), .disp_obs_y(disp_obs_y),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [CNT_W-1:0] stat(input int v);
    return STATS_ON ? CNT_W'(v) : '0;
  endfunction

  function automatic coord_t mk(input int a, input int b, input int c, input int d);
    coord_t r;
    r.dx = COORD_W'(a); r.dy = COORD_W'(b); r.ox = COORD_W'(c); r.oy = COORD_W'(d);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_disp(input string tag);
    check({tag, "_dx"}, disp_dino_x, exp_disp.dx);
    check({tag, "_dy"}, disp_dino_y, exp_disp.dy);
    check({tag, "_ox"}, disp_obs_x,  exp_disp.ox);
    check({tag, "_oy"}, disp_obs_y,  exp_disp.oy);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frames"},   frame_count,   stat(exp_frames));
    check({tag, "_overruns"}, overrun_count, stat(exp_ovr));
  endtask

  // From IDLE: request appears on the second edge after screen_ready rises
  task automatic start_frame(input string tag);
    screen_ready = 1'b1;
    tick(1);
    check({tag, "_req_early"}, frame_req, 1'b0);
    tick(1);
    check({tag, "_req"}, frame_req, 1'b1);
    screen_ready = 1'b0;
  endtask

  // From REQ: completes one CPU frame and checks the latch timing
  task automatic run_frame(input string tag, input coord_t c, input bit b2b, input bit chk_btn);
    coord_t e;
    sb_q.push_back(c);
    cpu_dino_x = c.dx; cpu_dino_y = c.dy; cpu_obs_x = c.ox; cpu_obs_y = c.oy;
    cpu_done = 1'b1;
    tick(3);
    check({tag, "_req_wait"}, frame_req, 1'b1);
    if (b2b) screen_ready = 1'b1;
    tick(1);
    check({tag, "_req_latch"}, frame_req, 1'b0);
    check_disp({tag, "_hold"});
    if (chk_btn) check({tag, "_btn_latch"}, btn_status, 1'b1);
    tick(1);
    e = sb_q.pop_front();
    exp_disp = e;
    exp_frames++;
    check_disp({tag, "_disp"});
    check_counts(tag);
    check({tag, "_req_after"}, frame_req, b2b);
    if (chk_btn) check({tag, "_btn_after"}, btn_status, 1'b0);
    cpu_done = 1'b0;
    screen_ready = 1'b0;
    tick(3);
  endtask

  initial begin
    bit seen;
    n_checks = 0; n_pass = 0; exp_frames = 0; exp_ovr = 0;
    exp_disp = '0;
    reset_n = 1'b0; screen_ready = 1'b0; button_press = 1'b0; cpu_done = 1'b0;
    cpu_dino_x = '0; cpu_dino_y = '0; cpu_obs_x = '0; cpu_obs_y = '0;
    tick(2);
    check("rst_req", frame_req, 1'b0);
    check("rst_btn", btn_status, 1'b0);
    check_disp("rst");
    check_counts("rst");
    reset_n = 1'b1;
    tick(3);

    // cpu_done while idle is ignored
    cpu_dino_x = 32'd7; cpu_obs_y = 32'd9; cpu_done = 1'b1;
    tick(6);
    check("idle_done_req", frame_req, 1'b0);
    check_disp("idle_done");
    check_counts("idle_done");
    cpu_done = 1'b0;
    tick(3);

    start_frame("nom");
    run_frame("nom", mk(120, 400, 600, 400), 1'b0, 1'b0);
    check("nom_idle", frame_req, 1'b0);

    // Overrun: second frame slot while still waiting on the CPU
    start_frame("ovr");
    tick(2);
    screen_ready = 1'b1;
    tick(1);
    screen_ready = 1'b0;
    tick(2);
    exp_ovr++;
    check("ovr_req", frame_req, 1'b1);
    check_disp("ovr_hold");
    check_counts("ovr");
    run_frame("ovr_done", mk(200, 380, 550, 390), 1'b0, 1'b0);

    // Back-to-back: frame slot lands in the LATCH cycle
    start_frame("b2b");
    run_frame("b2b_a", mk(130, 410, 580, 400), 1'b1, 1'b0);
    run_frame("b2b_b", mk(140, 420, 560, 395), 1'b0, 1'b0);

    // Short glitch never reaches btn_status
    seen = 1'b0;
    button_press = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(1); seen |= btn_status; end
    button_press = 1'b0;
    for (int i = 0; i < 25; i++) begin tick(1); seen |= btn_status; end
    check("glitch_btn", seen, 1'b0);

    // 40-cycle press, released long before the frame latches
    button_press = 1'b1;
    tick(DEB + 2);
    check("press_btn_pre", btn_status, 1'b0);
    tick(1);
    check("press_btn_rise", btn_status, 1'b1);
    tick(40 - DEB - 3);
    button_press = 1'b0;
    tick(30);
    check("press_btn_sticky", btn_status, 1'b1);
    start_frame("btn");
    check("btn_req_sticky", btn_status, 1'b1);
    run_frame("btn", mk(150, 400, 520, 400), 1'b0, 1'b1);

    // Asynchronous reset in REQ with populated display registers
    start_frame("rst2");
    #2 reset_n = 1'b0;
    #1;
    exp_disp = '0; exp_frames = 0; exp_ovr = 0;
    check("async_rst_req", frame_req, 1'b0);
    check_disp("async_rst");
    check_counts("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    tick(4);
    check("post_rst_idle", frame_req, 1'b0);
    start_frame("post_rst");
    run_frame("post_rst", mk(160, 400, 500, 400), 1'b0, 1'b0);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
